mult_datapath: RTL and testbench
================================

MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter: N, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  from controller: capture operands, clear accumulator and counter.
REQ-005 sh  input  1  from controller: shift accumulator right one bit, advance counter.
REQ-006 ad  input  1  from controller: add multiplicand into accumulator upper half.
REQ-007 mcand  input  N  multiplicand, unsigned, sampled only on load.
REQ-008 mplier  input  N  multiplier, unsigned, sampled only on load.
REQ-009 M  output  1  current multiplier LSB (ACC[0]) to controller, combinational from registers.
REQ-010 K  output  1  to controller, high when counter == N-1, combinational from registers.
REQ-011 product  output  2N  ACC[2N-1:0], unsigned result, valid after final shift.

Function
REQ-012 Internal state SHALL be: A (N bits, multiplicand), ACC (2N+1 bits), CNT (ceil(log2 N) bits).
REQ-013 load SHALL set A=mcand, ACC[2N:N]=0, ACC[N-1:0]=mplier, CNT=0 at the next edge.
REQ-014 ad alone SHALL set ACC[2N:N] = ACC[2N-1:N] + A (N+1-bit result incl. carry); ACC[N-1:0] and CNT unchanged.
REQ-015 sh alone SHALL set ACC = ACC >> 1 (zero fill at bit 2N), CNT = CNT+1.
REQ-016 ad and sh together SHALL perform the add, then shift the sum, in one cycle; CNT+1.
REQ-017 Priority: load overrides ad and sh in the same cycle; no other combination is illegal.
REQ-018 No strobe asserted: all registers hold.
REQ-019 CNT SHALL wrap from 2^width-1 to 0 on sh; no saturation; K follows CNT value only.
REQ-020 Sequence load, then N x (optional ad, sh) SHALL leave product = mcand * mplier exactly; no overflow possible.
REQ-021 K SHALL rise in the cycle after the (N-1)th sh, so the controller's Nth sh is its last.
REQ-022 M, K, product SHALL be glitch-free register-derived values; no combinational path from load/sh/ad to outputs.
REQ-023 Changing mcand/mplier outside a load cycle SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately clear A, ACC, CNT (and p_valid if present) regardless of clk.
REQ-025 Under reset: M=0, K=0 (for N>1), product=0.
REQ-026 Reset mid-operation SHALL abandon the product; first edge after rst_n rises obeys strobes normally.

Configuration
REQ-027 Macro MULT_PRODUCT_VALID_EN SHALL, when defined, add output p_valid (1 bit, registered).
REQ-028 With macro: p_valid set on the edge where sh is high and K is high; cleared by load or reset; otherwise holds.
REQ-029 Without macro: port p_valid absent; all other behaviour identical.

Verification
REQ-030 N=4, load mcand=13 mplier=11, then per-bit ad(if M) and sh x4 -> product=143, K high after 3rd sh.
REQ-031 N=4, mcand=15 mplier=15, ad+sh combined each cycle x4 -> product=225, M sequence 1,1,1,1.
REQ-032 N=4, mcand=9 mplier=0, sh only x4 -> product=0, M=0 throughout, CNT wraps to 0 after 4th sh.
REQ-033 N=4, load 7x5, 2 shifts, then load 3x6 with sh high same cycle -> restart, CNT=0, final product=18.
REQ-034 N=4, rst_n low mid-operation between edges -> A/ACC/CNT/product cleared immediately, M=0, K=0.
REQ-035 With MULT_PRODUCT_VALID_EN: 13x11 run -> p_valid rises with final sh, holds until next load clears it.

Source files
------------

// File: rtl/mult_datapath.sv
// mult_datapath: shift-and-add multiplier datapath driven by an external
// controller through load/sh/ad strobes. Holds the multiplicand (A), a
// 2N+1-bit accumulator (ACC, upper N+1 bits partial product incl. carry,
// lower N bits remaining multiplier) and a step counter (CNT).
// Optional feature: define MULT_PRODUCT_VALID_EN to add the registered
// p_valid output, which flags the completion of the final shift.
module mult_datapath #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           sh,
  input  logic           ad,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           M,
  output logic           K,
  output logic [2*N-1:0] product
`ifdef MULT_PRODUCT_VALID_EN
  ,
  output logic           p_valid
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N-1:0]   a_q, a_d;
  logic [2*N:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     sum;
  logic [2*N:0]   acc_sum;

  // Add A into the upper half; ACC[2N] is overwritten by the carry, not summed.
  always_comb begin
    sum     = {1'b0, acc_q[2*N-1:N]} + {1'b0, a_q};
    acc_sum = acc_q;
    if (ad) begin
      acc_sum = {sum, acc_q[N-1:0]};
    end
  end

  // Next-state selection: load wins, otherwise shift (of the sum when ad is
  // also high), otherwise add alone, otherwise hold.
  always_comb begin
    a_d   = a_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      a_d   = mcand;
      acc_d = {{(N+1){1'b0}}, mplier};
      cnt_d = '0;
    end else if (sh) begin
      acc_d = acc_sum >> 1;
      cnt_d = cnt_q + CNT_ONE;
    end else if (ad) begin
      acc_d = acc_sum;
    end
  end

  // Datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are decoded from registers only, never from the strobes.
  always_comb begin
    M       = acc_q[0];
    K       = (cnt_q == CNT_LAST);
    product = acc_q[2*N-1:0];
  end

`ifdef MULT_PRODUCT_VALID_EN
  logic pv_q, pv_d;

  // p_valid sets on the last shift (sh while K), clears on load, else holds.
  always_comb begin
    pv_d = pv_q;
    if (load) begin
      pv_d = 1'b0;
    end else if (sh && K) begin
      pv_d = 1'b1;
    end
  end

  // p_valid register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= 1'b0;
    end else begin
      pv_q <= pv_d;
    end
  end

  assign p_valid = pv_q;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed testbench for mult_datapath (N=4). Expected values come from an
// arithmetic model of shift-and-add: after i shifts the accumulator holds
// (mcand * (mplier mod 2^i)) << (N-i) | (mplier >> i).
module tb_mult_datapath;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load = 1'b0;
  logic           sh = 1'b0;
  logic           ad = 1'b0;
  logic [N-1:0]   mcand = '0;
  logic [N-1:0]   mplier = '0;
  logic           M;
  logic           K;
  logic [2*N-1:0] product;
`ifdef MULT_PRODUCT_VALID_EN
  logic           p_valid;
`endif

  mult_datapath #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .sh      (sh),
    .ad      (ad),
    .mcand   (mcand),
    .mplier  (mplier),
    .M       (M),
    .K       (K),
    .product (product)
`ifdef MULT_PRODUCT_VALID_EN
    ,
    .p_valid (p_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           m;
    logic           k;
    logic           pv;
    logic [2*N-1:0] prod;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int   mc = 0;
  int   mp = 0;
  int   nsh = 0;
  int   extra = 0;
  logic pv_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int acc_model(input int i);
    int prod;
    prod = mc * mp;
    if (i >= N) return prod >> (i - N);
    return ((mc * (mp % (1 << i))) << (N - i)) | (mp >> i);
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, "_prod"}, {24'd0, product}, {24'd0, e.prod});
    chk({tag, "_M"}, {31'd0, M}, {31'd0, e.m});
    chk({tag, "_K"}, {31'd0, K}, {31'd0, e.k});
`ifdef MULT_PRODUCT_VALID_EN
    chk({tag, "_pv"}, {31'd0, p_valid}, {31'd0, e.pv});
`endif
  endtask

  // One clock of stimulus: drive strobes/operands at negedge, update the
  // model, push the expectation, then compare just after the rising edge.
  task automatic cycle(input logic l, input logic s, input logic a,
                       input int nmc, input int nmp, input string tag);
    exp_t e;
    exp_t got;
    int   acc;
    @(negedge clk);
    load   = l;
    sh     = s;
    ad     = a;
    mcand  = 4'(nmc);
    mplier = 4'(nmp);
    if (l) begin
      mc = nmc; mp = nmp; nsh = 0; extra = 0; pv_m = 1'b0;
    end else if (s) begin
      if ((nsh % N) == N - 1) pv_m = 1'b1;
      nsh++;
      extra = 0;
    end else if (a) begin
      extra = mc << N;
    end
    acc    = acc_model(nsh) + extra;
    e.m    = acc[0];
    e.k    = ((nsh % N) == N - 1);
    e.pv   = pv_m;
    e.prod = acc[2*N-1:0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_outputs(tag, got);
  endtask

  function automatic int rnd();
    return int'($urandom_range(15));
  endfunction

  initial begin
    exp_t zero_e;
    int   b;
    zero_e = '0;

    // Reset state before any clock edge
    #1;
    check_outputs("reset", zero_e);
    #1 rst_n = 1'b1;

    // 13 x 11 with separate ad and sh cycles; operands scrambled off-load
    cycle(1'b1, 1'b0, 1'b0, 13, 11, "ld13x11");
    b = 11;
    for (int i = 0; i < N; i++) begin
      if (b[i]) cycle(1'b0, 1'b0, 1'b1, rnd(), rnd(), "m13_ad");
      cycle(1'b0, 1'b1, 1'b0, rnd(), rnd(), "m13_sh");
    end
    chk("m13_final", {24'd0, product}, 32'd143);
    cycle(1'b0, 1'b0, 1'b0, 5, 6, "m13_hold");
    cycle(1'b0, 1'b0, 1'b0, 2, 9, "m13_hold2");

    // 15 x 15 with combined ad+sh every cycle
    cycle(1'b1, 1'b0, 1'b0, 15, 15, "ld15x15");
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 1'b1, rnd(), rnd(), "m15_adsh");
    chk("m15_final", {24'd0, product}, 32'd225);

    // 9 x 0 shift only, then keep shifting to see CNT wrap and K return
    cycle(1'b1, 1'b0, 1'b0, 9, 0, "ld9x0");
    for (int i = 0; i < N + 3; i++) cycle(1'b0, 1'b1, 1'b0, rnd(), rnd(), "m9_sh");
    chk("m9_final", {24'd0, product}, 32'd0);

    // 7 x 5 interrupted by a load with sh and ad also high
    cycle(1'b1, 1'b0, 1'b0, 7, 5, "ld7x5");
    cycle(1'b0, 1'b1, 1'b1, rnd(), rnd(), "m7_adsh");
    cycle(1'b0, 1'b1, 1'b0, rnd(), rnd(), "m7_sh");
    cycle(1'b1, 1'b1, 1'b1, 3, 6, "ld3x6_over");
    b = 6;
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, b[i], rnd(), rnd(), "m3_step");
    chk("m3_final", {24'd0, product}, 32'd18);

    // Reset asserted between edges in the middle of a 15 x 15 run
    cycle(1'b1, 1'b0, 1'b0, 15, 15, "ld15_rst");
    for (int i = 0; i < N - 1; i++) cycle(1'b0, 1'b1, 1'b1, rnd(), rnd(), "m15r_adsh");
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", zero_e);
    load = 1'b0; sh = 1'b1; ad = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_held", zero_e);
    @(negedge clk);
    rst_n = 1'b1; sh = 1'b0; ad = 1'b0;
    mc = 0; mp = 0; nsh = 0; extra = 0; pv_m = 1'b0;

    // First edge after reset obeys strobes: full 13 x 11 run
    cycle(1'b1, 1'b0, 1'b0, 13, 11, "ld_after_rst");
    b = 11;
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, b[i], rnd(), rnd(), "post_rst_step");
    chk("post_rst_final", {24'd0, product}, 32'd143);
    cycle(1'b1, 1'b0, 1'b0, 2, 3, "ld_clear_pv");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
